// File: rtl/pipe_hazard_sb_if.sv
// Hazard-unit bus: ID/E/M pipeline decode fields in, forwarding selects,
// stall and long-latency write-back out.
interface pipe_hazard_sb_if #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
);
    logic [RA_W-1:0]  id_rs;
    logic [RA_W-1:0]  id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic [RA_W-1:0]  id_wn;
    logic             id_wreg;
    logic             id_long;
    logic             id_branch;
    logic             id_kill;
    logic             e_wreg;
    logic             e_m2reg;
    logic [RA_W-1:0]  e_wn;
    logic             m_wreg;
    logic             m_m2reg;
    logic [RA_W-1:0]  m_wn;
    logic [1:0]       fwda;
    logic [1:0]       fwdb;
    logic             stall;
    logic             long_busy;
    logic             long_wb;
    logic [RA_W-1:0]  long_wn;
    logic [CNT_W-1:0] stall_cnt;

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_wn, id_wreg, id_long,
               id_branch, id_kill, e_wreg, e_m2reg, e_wn, m_wreg, m_m2reg, m_wn,
        output fwda, fwdb, stall, long_busy, long_wb, long_wn, stall_cnt
    );

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_wn, id_wreg, id_long,
               id_branch, id_kill, e_wreg, e_m2reg, e_wn, m_wreg, m_m2reg, m_wn,
        input  fwda, fwdb, stall, long_busy, long_wb, long_wn, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_sb.sv
// Hazard/forwarding unit for the 5-stage pipe with a one-entry scoreboard
// tracking a single in-flight long-latency (mul/div) result.
module pipe_hazard_sb #(
    parameter int RA_W     = 5,
    parameter int LONG_LAT = 4,
    parameter int BR_EARLY = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clock,
    input  logic             resetn,
    pipe_hazard_sb_if.slave  hz
);
    localparam int CW = 4;

    typedef enum logic {S_IDLE, S_BUSY} sb_state_e;

    sb_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [RA_W-1:0]  sb_wn_q, sb_wn_d;
    logic             long_wb_q, long_wb_d;
    logic [RA_W-1:0]  long_wn_q, long_wn_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    function automatic logic src_hit(input logic [RA_W-1:0] src,
                                     input logic            use_src,
                                     input logic [RA_W-1:0] wn);
        return use_src && (src != '0) && (src == wn);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] src,
                                           input logic            use_src);
        logic [1:0] sel;
        sel = 2'b00;
        if (hz.e_wreg && !hz.e_m2reg && src_hit(src, use_src, hz.e_wn))
            sel = 2'b01;
        else if (hz.m_wreg && src_hit(src, use_src, hz.m_wn))
            sel = {1'b1, hz.m_m2reg};
        return sel;
    endfunction

    logic long_busy;
    logic sb_block;
    logic e_hit;
    logic haz_load_use;
    logic haz_raw;
    logic haz_waw;
    logic haz_struct;
    logic haz_branch;
    logic stall;
    logic issue;

    assign long_busy = (state_q == S_BUSY);
    // The write-back cycle bypasses through the register file, so the
    // scoreboard only blocks consumers before the pulse.
    assign sb_block  = long_busy && !long_wb_q;

    assign e_hit = hz.e_wreg && (src_hit(hz.id_rs, hz.id_use_rs, hz.e_wn) ||
                                 src_hit(hz.id_rt, hz.id_use_rt, hz.e_wn));

    assign haz_load_use = e_hit && hz.e_m2reg;
    assign haz_raw      = sb_block && (src_hit(hz.id_rs, hz.id_use_rs, sb_wn_q) ||
                                       src_hit(hz.id_rt, hz.id_use_rt, sb_wn_q));
    assign haz_waw      = sb_block && (hz.id_wreg || hz.id_long) && (hz.id_wn == sb_wn_q);
    assign haz_struct   = sb_block && hz.id_long;
    assign haz_branch   = (BR_EARLY != 0) && hz.id_branch && e_hit;

    assign stall = !hz.id_kill &&
                   (haz_load_use || haz_raw || haz_waw || haz_struct || haz_branch);

    // Long ops to r0 still leave ID but never occupy the scoreboard.
    assign issue = hz.id_long && !hz.id_kill && !stall && (hz.id_wn != '0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sb_wn_d     = sb_wn_q;
        long_wb_d   = 1'b0;
        long_wn_d   = '0;
        stall_cnt_d = stall_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (issue) begin
                    state_d = S_BUSY;
                    sb_wn_d = hz.id_wn;
                    cnt_d   = CW'(LONG_LAT - 1);
                end
            end
            S_BUSY: begin
                if (long_wb_q) begin
                    if (issue) begin
                        sb_wn_d = hz.id_wn;
                        cnt_d   = CW'(LONG_LAT - 1);
                    end else begin
                        state_d = S_IDLE;
                        sb_wn_d = '0;
                        cnt_d   = '0;
                    end
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    long_wb_d = 1'b1;
                    long_wn_d = sb_wn_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (stall && !(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            sb_wn_q     <= '0;
            long_wb_q   <= 1'b0;
            long_wn_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sb_wn_q     <= sb_wn_d;
            long_wb_q   <= long_wb_d;
            long_wn_q   <= long_wn_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hz.fwda      = fwd_sel(hz.id_rs, hz.id_use_rs);
    assign hz.fwdb      = fwd_sel(hz.id_rt, hz.id_use_rt);
    assign hz.stall     = stall;
    assign hz.long_busy = long_busy;
    assign hz.long_wb   = long_wb_q;
    assign hz.long_wn   = long_wn_q;
    assign hz.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_sb.sv
// Bench for pipe_hazard_sb: directed scenarios plus a randomized run checked
// against a timeline model of the long-op scoreboard.
module tb_pipe_hazard_sb;
    localparam int RA_W   = 5;
    localparam int LAT    = 4;
    localparam int CNT_W  = 16;
    localparam int CNT2_W = 4;
    localparam longint CMAX = (64'd1 << CNT_W) - 1;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    pipe_hazard_sb_if #(.RA_W(RA_W), .CNT_W(CNT_W))  h1();
    pipe_hazard_sb_if #(.RA_W(RA_W), .CNT_W(CNT2_W)) h2();

    pipe_hazard_sb #(.RA_W(RA_W), .LONG_LAT(LAT), .BR_EARLY(1), .CNT_W(CNT_W)) dut1 (
        .clock(clock), .resetn(resetn), .hz(h1.slave));
    pipe_hazard_sb #(.RA_W(RA_W), .LONG_LAT(LAT), .BR_EARLY(0), .CNT_W(CNT2_W)) dut2 (
        .clock(clock), .resetn(resetn), .hz(h2.slave));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model for dut1: a long op issued at edge k occupies cycles
    // k..k+LAT and writes back in cycle k+LAT.
    int          cyc = 0;
    bit          m_have = 1'b0;
    int          m_issue = 0;
    logic [4:0]  m_dest = '0;
    longint      m_cnt = 0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic bit m_busy(input int k);
        return m_have && (k >= m_issue) && (k <= m_issue + LAT);
    endfunction

    function automatic bit m_wb(input int k);
        return m_have && (k == m_issue + LAT);
    endfunction

    function automatic bit hits(input logic [4:0] src, input logic u, input logic [4:0] wn);
        return u && (src != 0) && (src == wn);
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [4:0] src, input logic u);
        if (h1.e_wreg && !h1.e_m2reg && hits(src, u, h1.e_wn)) return 2'b01;
        if (h1.m_wreg && hits(src, u, h1.m_wn)) return h1.m_m2reg ? 2'b11 : 2'b10;
        return 2'b00;
    endfunction

    function automatic bit exp_stall();
        bit blk, ehit, any;
        blk  = m_busy(cyc) && !m_wb(cyc);
        ehit = h1.e_wreg && (hits(h1.id_rs, h1.id_use_rs, h1.e_wn) ||
                             hits(h1.id_rt, h1.id_use_rt, h1.e_wn));
        any  = (ehit && h1.e_m2reg) ||
               (blk && (hits(h1.id_rs, h1.id_use_rs, m_dest) ||
                        hits(h1.id_rt, h1.id_use_rt, m_dest))) ||
               (blk && (h1.id_wreg || h1.id_long) && (h1.id_wn == m_dest)) ||
               (blk && h1.id_long) ||
               (h1.id_branch && ehit);
        return !h1.id_kill && any;
    endfunction

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_have <= 1'b0;
            m_cnt  <= 0;
        end else begin
            if (exp_stall()) m_cnt <= (m_cnt == CMAX) ? CMAX : m_cnt + 1;
            if (h1.id_long && !h1.id_kill && !exp_stall() && h1.id_wn != 0) begin
                m_have  <= 1'b1;
                m_issue <= cyc + 1;
                m_dest  <= h1.id_wn;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle1();
        h1.id_rs = '0; h1.id_rt = '0; h1.id_use_rs = 0; h1.id_use_rt = 0;
        h1.id_wn = '0; h1.id_wreg = 0; h1.id_long = 0; h1.id_branch = 0;
        h1.id_kill = 0; h1.e_wreg = 0; h1.e_m2reg = 0; h1.e_wn = '0;
        h1.m_wreg = 0; h1.m_m2reg = 0; h1.m_wn = '0;
    endtask

    task automatic idle2();
        h2.id_rs = '0; h2.id_rt = '0; h2.id_use_rs = 0; h2.id_use_rt = 0;
        h2.id_wn = '0; h2.id_wreg = 0; h2.id_long = 0; h2.id_branch = 0;
        h2.id_kill = 0; h2.e_wreg = 0; h2.e_m2reg = 0; h2.e_wn = '0;
        h2.m_wreg = 0; h2.m_m2reg = 0; h2.m_wn = '0;
    endtask

    task automatic test_reset();
        idle1(); idle2();
        #2;
        n_cmp++; if (h1.long_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", h1.long_busy); end
        n_cmp++; if (h1.long_wb !== 1'b0) begin n_bad++; $display("FAIL reset_wb: got %b want 0", h1.long_wb); end
        n_cmp++; if (h1.long_wn !== 5'd0) begin n_bad++; $display("FAIL reset_wn: got %0d want 0", h1.long_wn); end
        n_cmp++; if (h1.stall_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", h1.stall_cnt); end
        n_cmp++; if (h1.stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", h1.stall); end
        tick(); tick();
        resetn = 1'b1;
        #1;
        n_cmp++; if (h1.long_busy !== 1'b0) begin n_bad++; $display("FAIL post_reset_busy: got %b want 0", h1.long_busy); end
    endtask

    task automatic test_forwarding();
        tick(); idle1();
        h1.e_wreg = 1; h1.e_wn = 5; h1.m_wreg = 1; h1.m_wn = 5; h1.m_m2reg = 1;
        h1.id_rs = 5; h1.id_use_rs = 1; h1.id_rt = 5; h1.id_use_rt = 0;
        #1;
        n_cmp++; if (h1.fwda !== 2'b01) begin n_bad++; $display("FAIL fwd_e_prio: got %b want 01", h1.fwda); end
        n_cmp++; if (h1.fwdb !== 2'b00) begin n_bad++; $display("FAIL fwd_unused_rt: got %b want 00", h1.fwdb); end
        n_cmp++; if (h1.stall !== 1'b0) begin n_bad++; $display("FAIL fwd_nostall: got %b want 0", h1.stall); end
        h1.e_wreg = 0;
        #1;
        n_cmp++; if (h1.fwda !== 2'b11) begin n_bad++; $display("FAIL fwd_m_mem: got %b want 11", h1.fwda); end
        h1.m_m2reg = 0; h1.id_use_rt = 1;
        #1;
        n_cmp++; if (h1.fwdb !== 2'b10) begin n_bad++; $display("FAIL fwd_m_alu: got %b want 10", h1.fwdb); end
        h1.id_rs = 0; h1.id_rt = 0; h1.e_wn = 0; h1.m_wn = 0; h1.e_wreg = 1;
        #1;
        n_cmp++; if (h1.fwda !== 2'b00) begin n_bad++; $display("FAIL fwd_r0: got %b want 00", h1.fwda); end
        n_cmp++; if (h1.stall !== 1'b0) begin n_bad++; $display("FAIL fwd_r0_stall: got %b want 0", h1.stall); end
    endtask

    task automatic test_load_use();
        tick(); idle1();
        h1.e_wreg = 1; h1.e_m2reg = 1; h1.e_wn = 7; h1.id_rt = 7; h1.id_use_rt = 1;
        #1;
        n_cmp++; if (h1.stall !== 1'b1) begin n_bad++; $display("FAIL lu_stall: got %b want 1", h1.stall); end
        n_cmp++; if (h1.stall_cnt !== 16'd0) begin n_bad++; $display("FAIL lu_cnt0: got %0d want 0", h1.stall_cnt); end
        tick(); idle1();
        #1;
        n_cmp++; if (h1.stall !== 1'b0) begin n_bad++; $display("FAIL lu_release: got %b want 0", h1.stall); end
        n_cmp++; if (h1.stall_cnt !== 16'd1) begin n_bad++; $display("FAIL lu_cnt1: got %0d want 1", h1.stall_cnt); end
        h1.e_wreg = 1; h1.e_m2reg = 1; h1.e_wn = 7; h1.id_rt = 7; h1.id_use_rt = 1; h1.id_kill = 1;
        #1;
        n_cmp++; if (h1.stall !== 1'b0) begin n_bad++; $display("FAIL lu_kill: got %b want 0", h1.stall); end
    endtask

    task automatic test_long_op();
        tick(); idle1();
        h1.id_long = 1; h1.id_wn = 9;
        #1;
        n_cmp++; if (h1.stall !== 1'b0) begin n_bad++; $display("FAIL long_issue_stall: got %b want 0", h1.stall); end
        tick(); idle1();
        h1.id_rs = 9; h1.id_use_rs = 1;
        #1;
        n_cmp++; if (h1.long_busy !== 1'b1) begin n_bad++; $display("FAIL long_busy_T: got %b want 1", h1.long_busy); end
        n_cmp++; if (h1.stall !== 1'b1) begin n_bad++; $display("FAIL long_raw_T: got %b want 1", h1.stall); end
        for (int i = 1; i <= 3; i++) begin
            tick(); #1;
            n_cmp++; if (h1.stall !== 1'b1 || h1.long_wb !== 1'b0) begin n_bad++; $display("FAIL long_wait%0d: stall=%b wb=%b want 1/0", i, h1.stall, h1.long_wb); end
        end
        tick(); #1;
        n_cmp++; if (h1.long_wb !== 1'b1 || h1.long_wn !== 5'd9) begin n_bad++; $display("FAIL long_wb: wb=%b wn=%0d want 1/9", h1.long_wb, h1.long_wn); end
        n_cmp++; if (h1.stall !== 1'b0 || h1.long_busy !== 1'b1) begin n_bad++; $display("FAIL long_release: stall=%b busy=%b want 0/1", h1.stall, h1.long_busy); end
        tick(); idle1(); #1;
        n_cmp++; if (h1.long_busy !== 1'b0 || h1.long_wb !== 1'b0) begin n_bad++; $display("FAIL long_idle: busy=%b wb=%b want 0/0", h1.long_busy, h1.long_wb); end
    endtask

    task automatic test_back_to_back();
        tick(); idle1();
        h1.id_long = 1; h1.id_wn = 9;
        tick();
        h1.id_wn = 10;
        #1;
        n_cmp++; if (h1.stall !== 1'b1) begin n_bad++; $display("FAIL b2b_struct: got %b want 1", h1.stall); end
        for (int i = 1; i <= 3; i++) begin
            tick(); #1;
            n_cmp++; if (h1.stall !== 1'b1) begin n_bad++; $display("FAIL b2b_hold%0d: got %b want 1", i, h1.stall); end
        end
        tick(); #1;
        n_cmp++; if (h1.long_wb !== 1'b1 || h1.long_wn !== 5'd9 || h1.stall !== 1'b0) begin n_bad++; $display("FAIL b2b_wb1: wb=%b wn=%0d stall=%b want 1/9/0", h1.long_wb, h1.long_wn, h1.stall); end
        tick(); idle1(); #1;
        n_cmp++; if (h1.long_busy !== 1'b1 || h1.long_wb !== 1'b0) begin n_bad++; $display("FAIL b2b_nogap: busy=%b wb=%b want 1/0", h1.long_busy, h1.long_wb); end
        for (int i = 1; i <= 3; i++) begin
            tick(); #1;
            n_cmp++; if (h1.long_wb !== 1'b0) begin n_bad++; $display("FAIL b2b_early%0d: wb=%b want 0", i, h1.long_wb); end
        end
        tick(); #1;
        n_cmp++; if (h1.long_wb !== 1'b1 || h1.long_wn !== 5'd10) begin n_bad++; $display("FAIL b2b_wb2: wb=%b wn=%0d want 1/10", h1.long_wb, h1.long_wn); end
        tick(); #1;
        n_cmp++; if (h1.long_busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle: busy=%b want 0", h1.long_busy); end
    endtask

    task automatic test_waw();
        tick(); idle1();
        h1.id_long = 1; h1.id_wn = 4;
        tick(); idle1();
        h1.id_wreg = 1; h1.id_wn = 4;
        #1;
        n_cmp++; if (h1.stall !== 1'b1) begin n_bad++; $display("FAIL waw_same: got %b want 1", h1.stall); end
        h1.id_wn = 5;
        #1;
        n_cmp++; if (h1.stall !== 1'b0) begin n_bad++; $display("FAIL waw_other: got %b want 0", h1.stall); end
        idle1();
        repeat (5) tick();
        #1;
        n_cmp++; if (h1.long_busy !== 1'b0) begin n_bad++; $display("FAIL waw_idle: busy=%b want 0", h1.long_busy); end
        h1.id_long = 1; h1.id_wn = 0;
        tick(); idle1(); #1;
        n_cmp++; if (h1.long_busy !== 1'b0) begin n_bad++; $display("FAIL long_r0: busy=%b want 0", h1.long_busy); end
    endtask

    task automatic test_branch_early();
        tick(); idle1(); idle2();
        h1.id_branch = 1; h1.id_rs = 3; h1.id_use_rs = 1; h1.e_wreg = 1; h1.e_wn = 3;
        h2.id_branch = 1; h2.id_rs = 3; h2.id_use_rs = 1; h2.e_wreg = 1; h2.e_wn = 3;
        #1;
        n_cmp++; if (h1.stall !== 1'b1) begin n_bad++; $display("FAIL br_early_stall: got %b want 1", h1.stall); end
        n_cmp++; if (h2.stall !== 1'b0) begin n_bad++; $display("FAIL br_late_stall: got %b want 0", h2.stall); end
        n_cmp++; if (h2.fwda !== 2'b01) begin n_bad++; $display("FAIL br_late_fwd: got %b want 01", h2.fwda); end
        tick();
        h1.e_wreg = 0; h1.e_wn = 0; h1.m_wreg = 1; h1.m_wn = 3;
        idle2();
        #1;
        n_cmp++; if (h1.stall !== 1'b0 || h1.fwda !== 2'b10) begin n_bad++; $display("FAIL br_early_fwd: stall=%b fwda=%b want 0/10", h1.stall, h1.fwda); end
    endtask

    task automatic test_reset_mid_op();
        tick(); idle1();
        h1.id_long = 1; h1.id_wn = 12;
        tick(); idle1();
        h1.id_rs = 12; h1.id_use_rs = 1;
        tick();
        resetn = 1'b0;
        #1;
        n_cmp++; if (h1.long_busy !== 1'b0 || h1.long_wb !== 1'b0 || h1.long_wn !== 5'd0) begin n_bad++; $display("FAIL rst_mid_sb: busy=%b wb=%b wn=%0d want 0/0/0", h1.long_busy, h1.long_wb, h1.long_wn); end
        n_cmp++; if (h1.stall_cnt !== 16'd0 || h1.stall !== 1'b0) begin n_bad++; $display("FAIL rst_mid_stall: cnt=%0d stall=%b want 0/0", h1.stall_cnt, h1.stall); end
        tick();
        resetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_cmp++; if (h1.long_wb !== 1'b0 || h1.stall !== 1'b0) begin n_bad++; $display("FAIL rst_no_wb%0d: wb=%b stall=%b want 0/0", i, h1.long_wb, h1.stall); end
            tick();
        end
        idle1();
    endtask

    task automatic test_saturation();
        logic [CNT2_W-1:0] want;
        idle1(); idle2();
        tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        h2.e_wreg = 1; h2.e_m2reg = 1; h2.e_wn = 6; h2.id_rs = 6; h2.id_use_rs = 1;
        #1;
        n_cmp++; if (h2.stall !== 1'b1 || h2.stall_cnt !== 4'd0) begin n_bad++; $display("FAIL sat_start: stall=%b cnt=%0d want 1/0", h2.stall, h2.stall_cnt); end
        for (int i = 1; i <= (1 << CNT2_W) + 3; i++) begin
            tick(); #1;
            want = (i < 15) ? CNT2_W'(i) : 4'd15;
            n_cmp++; if (h2.stall_cnt !== want) begin n_bad++; $display("FAIL sat_cnt%0d: got %0d want %0d", i, h2.stall_cnt, want); end
        end
        idle2();
    endtask

    task automatic test_random();
        logic [1:0] ea, eb;
        for (int i = 0; i < 600; i++) begin
            tick();
            h1.id_rs = 5'($urandom_range(0, 7));
            h1.id_rt = 5'($urandom_range(0, 7));
            h1.id_use_rs = 1'($urandom);
            h1.id_use_rt = 1'($urandom);
            h1.id_wn = 5'($urandom_range(0, 7));
            h1.id_wreg = 1'($urandom);
            h1.id_long = ($urandom_range(0, 5) == 0);
            h1.id_branch = ($urandom_range(0, 3) == 0);
            h1.id_kill = ($urandom_range(0, 9) == 0);
            h1.e_wreg = 1'($urandom);
            h1.e_m2reg = ($urandom_range(0, 2) == 0);
            h1.e_wn = 5'($urandom_range(0, 7));
            h1.m_wreg = 1'($urandom);
            h1.m_m2reg = 1'($urandom);
            h1.m_wn = 5'($urandom_range(0, 7));
            #1;
            ea = exp_fwd(h1.id_rs, h1.id_use_rs);
            eb = exp_fwd(h1.id_rt, h1.id_use_rt);
            n_cmp++; if (h1.fwda !== ea) begin n_bad++; $display("FAIL rnd_fwda@%0d: got %b want %b", i, h1.fwda, ea); end
            n_cmp++; if (h1.fwdb !== eb) begin n_bad++; $display("FAIL rnd_fwdb@%0d: got %b want %b", i, h1.fwdb, eb); end
            n_cmp++; if (h1.stall !== exp_stall()) begin n_bad++; $display("FAIL rnd_stall@%0d: got %b want %b", i, h1.stall, exp_stall()); end
            n_cmp++; if (h1.long_busy !== m_busy(cyc)) begin n_bad++; $display("FAIL rnd_busy@%0d: got %b want %b", i, h1.long_busy, m_busy(cyc)); end
            n_cmp++; if (h1.long_wb !== m_wb(cyc)) begin n_bad++; $display("FAIL rnd_wb@%0d: got %b want %b", i, h1.long_wb, m_wb(cyc)); end
            n_cmp++; if (h1.long_wn !== (m_wb(cyc) ? m_dest : 5'd0)) begin n_bad++; $display("FAIL rnd_wn@%0d: got %0d want %0d", i, h1.long_wn, m_wb(cyc) ? m_dest : 5'd0); end
            n_cmp++; if (h1.stall_cnt !== m_cnt[CNT_W-1:0]) begin n_bad++; $display("FAIL rnd_cnt@%0d: got %0d want %0d", i, h1.stall_cnt, m_cnt); end
        end
        idle1();
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_long_op();
        test_back_to_back();
        test_waw();
        test_branch_early();
        test_reset_mid_op();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
